fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction-fetch stage with decoupling queue. Owns the fetch PC, issues one
//  word-aligned read per cycle to a synchronous-read instruction memory, and buffers returned
//  words in a DEPTH-entry FIFO. Decode consumes through a valid/ready handshake. A redirect
//  (branch/jump resolved downstream) flushes the queue and kills the in-flight read.
// PARAMETERS
//  ADDR_W    32  width of PC and memory address
//  DATA_W    32  instruction word width
//  DEPTH     4   queue entries, power of two, >= 2
//  RESET_PC  0   PC loaded on reset
// PORTS
//  clk             in   1       clock, all state on rising edge
//  reset           in   1       synchronous, active-high
//  redirect_valid  in   1       load new PC, flush queue
//  redirect_pc     in   ADDR_W  target PC (low 2 bits ignored, forced 0)
//  imem_addr       out  ADDR_W  read address to instruction memory
//  imem_req        out  1       read issued this cycle
//  imem_rdata      in   DATA_W  read data, valid exactly 1 cycle after imem_req
//  instr_valid     out  1       head entry present
//  instr_ready     in   1       decode accepts head this cycle
//  instr           out  DATA_W  head instruction
//  pc_plus_4       out  ADDR_W  head entry PC + 4 (mod 2^ADDR_W)
// BEHAVIOUR
//  - Reset: pc_f=RESET_PC, queue empty, inflight=0; instr_valid=0, instr=0, pc_plus_4=0,
//    imem_req=0. Reset mid-operation discards queue and in-flight read identically.
//  - Issue: imem_req = !reset && !redirect_valid && (count + inflight + 0 < DEPTH) minus a pop
//    credit is NOT taken: issue only when count+inflight < DEPTH. imem_addr = pc_f.
//    On issue pc_f <= pc_f + 4 (wraps modulo 2^ADDR_W); inflight <= 1 with tag pc_f.
//  - Return: cycle after issue, if inflight and not killed, push {imem_rdata, tag+4}.
//    Overflow impossible by issue rule; RTL asserts it in simulation.
//  - Pop: fires when instr_valid && instr_ready; head advances next cycle. Push and pop in same
//    cycle: count unchanged, pointers both advance (legal at full and empty boundaries;
//    empty+push+no pop -> instr_valid next cycle, no same-cycle bypass).
//  - Latency: redirect/reset edge -> first imem_req next cycle -> instr_valid 2 cycles after req.
//  - Redirect: highest priority. In that cycle: no issue, any pop ignored (handshake void),
//    queue cleared, inflight response dropped, pc_f <= {redirect_pc[ADDR_W-1:2],2'b00}.
//    Back-to-back redirects: last one wins.
//  - Outputs instr/pc_plus_4 show head entry, hold 0 when empty. Stable while valid && !ready.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetched[31:0] (pushes), perf_stall[31:0] (cycles
//  with issue blocked by full queue), perf_flush[31:0] (redirects); all reset to 0, saturate at
//  all-ones. Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  Shared package fetch_pkg: INSTR_NOP constant (32'h0), PC_INC constant (4), typedef of
//  queue entry {instr, pc_plus_4}. One sub-module: fetch_fifo (DEPTH-entry synchronous FIFO
//  with push/pop/flush, count output); PC, issue and kill logic live in fetch_queue.
// TESTING
//  1 reset, RESET_PC=0, ready=1, memory returns addr as data -> imem_addr 0,4,8...; instr at
//    head = 0,4,8 with pc_plus_4 = 4,8,12; first instr_valid cycle 2 after reset deassert.
//  2 ready=0 for 10 cycles -> exactly DEPTH=4 entries held, imem_req low, perf_stall counts;
//    release ready -> entries 0,4,8,12 drain in order, no loss/duplication.
//  3 redirect_valid with redirect_pc=0x100 while read of 0x10 in flight -> 0x10 word never
//    appears; next valid head instr from 0x100, pc_plus_4=0x104.
//  4 redirect and pop same cycle with queue full -> queue empty next cycle, pop ignored,
//    instr_valid=0; redirect_pc=0x203 -> fetch starts at 0x200.
//  5 pc_f=0xFFFFFFFC, ready=1 -> next imem_addr 0x0, head pc_plus_4=0x0 (wrap).
//  6 assert reset while queue holds 3 entries and read in flight -> next cycle instr_valid=0,
//    instr=0, imem_addr restarts at RESET_PC, stale response discarded.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and the queue-entry layout for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0;
    localparam int unsigned PC_INC    = 4;

    // Reference entry layout at the default 32-bit widths; fetch_queue builds a
    // width-parameterised equivalent with the same field order.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus_4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with push/pop/flush; head entry is read combinationally
// so a push is visible the cycle after it is written, with no same-cycle bypass.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !srst && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst && !flush) begin
            assert (!(push && !pop && count_reg == (PTR_W+1)'(DEPTH)));
            assert (!(pop && count_reg == '0));
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues one read per cycle and buffers words
// for decode. Define FETCH_PERF_EN to add the perf_fetched/perf_stall/perf_flush counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc_plus_4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc_plus_4;
    } entry_t;

    logic [ADDR_W-1:0] pc_f_reg;
    logic [ADDR_W-1:0] tag_reg;
    logic              inflight_reg;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              room;
    logic              issue;
    logic              push;
    logic              pop;
    logic              head_valid;
    entry_t            push_entry;
    entry_t            head_entry;
    logic              unused_pc_bits;

    assign unused_pc_bits = &{1'b0, redirect_pc[1:0]};

    // The in-flight read reserves a slot, so a full queue can never be overrun.
    assign occupancy  = {1'b0, fifo_count} + (CNT_W+1)'(inflight_reg);
    assign room       = occupancy < (CNT_W+1)'(DEPTH);
    assign issue      = !reset && !redirect_valid && room;
    assign push       = inflight_reg && !redirect_valid;
    assign head_valid = fifo_count != '0;
    assign pop        = head_valid && instr_ready && !redirect_valid;

    assign push_entry = '{instr: imem_rdata, pc_plus_4: tag_reg + ADDR_W'(PC_INC)};

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_reg     <= RESET_PC;
            tag_reg      <= '0;
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                tag_reg <= pc_f_reg;
            end
            if (redirect_valid) begin
                pc_f_reg <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (issue) begin
                pc_f_reg <= pc_f_reg + ADDR_W'(PC_INC);
            end
        end
    end

    assign imem_addr   = pc_f_reg;
    assign imem_req    = issue;
    assign instr_valid = head_valid;
    assign instr       = head_valid ? head_entry.instr : DATA_W'(INSTR_NOP);
    assign pc_plus_4   = head_valid ? head_entry.pc_plus_4 : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_flush_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_reg <= '0;
            perf_stall_reg   <= '0;
            perf_flush_reg   <= '0;
        end else begin
            if (push && perf_fetched_reg != '1) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (!redirect_valid && !room && perf_stall_reg != '1) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
            if (redirect_valid && perf_flush_reg != '1) begin
                perf_flush_reg <= perf_flush_reg + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_stall   = perf_stall_reg;
    assign perf_flush   = perf_flush_reg;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: startup vector table, directed corner sequences and a
// randomized phase, all checked against a queue-based fetch-stream model.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc_plus_4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    int tests_run = 0;
    int fails     = 0;
    bit chk_en    = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc_plus_4      (pc_plus_4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_flush     (perf_flush)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Instruction memory: word for the requested address one cycle later, junk otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: every issued PC becomes visible two cycles later, in order; a redirect
    // or reset discards everything outstanding and restarts the PC stream.
    typedef struct {
        logic [31:0] pc;
        int          t;
    } m_entry_t;

    m_entry_t    mq[$];
    logic [31:0] pc_m    = 32'h0;
    int          cyc_idx = 0;

    always @(negedge clk) begin
        logic        e_req;
        logic        e_vis;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        e_req   = !reset && !redirect_valid && (mq.size() < DEPTH);
        e_vis   = (mq.size() > 0) && (mq[0].t <= cyc_idx);
        e_instr = 32'h0;
        e_pc4   = 32'h0;
        if (e_vis) begin
            e_instr = mem_word(mq[0].pc);
            e_pc4   = mq[0].pc + 32'd4;
        end
        if (chk_en) begin
            check("mdl_req",   {31'b0, imem_req},    {31'b0, e_req});
            check("mdl_addr",  imem_addr,            pc_m);
            check("mdl_valid", {31'b0, instr_valid}, {31'b0, e_vis});
            check("mdl_instr", instr,                e_instr);
            check("mdl_pc4",   pc_plus_4,            e_pc4);
        end
        if (reset) begin
            mq.delete();
            pc_m = 32'h0;
        end else if (redirect_valid) begin
            mq.delete();
            pc_m = {redirect_pc[31:2], 2'b00};
        end else begin
            if (e_vis && instr_ready) begin
                void'(mq.pop_front());
            end
            if (e_req) begin
                mq.push_back('{pc: pc_m, t: cyc_idx + 2});
                pc_m = pc_m + 32'd4;
            end
        end
        cyc_idx++;
    end

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[9];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Startup stream, then a redirect to 0x100 that kills the read of 0x10.
        vecs[0] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h00,  1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h04,  1'b0, 32'h0, 32'h0};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h08,  1'b1, mem_word(32'h0), 32'h04};
        vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0C,  1'b1, mem_word(32'h4), 32'h08};
        vecs[4] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, mem_word(32'h8), 32'h0C};
        vecs[5] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h14,  1'b1, mem_word(32'hC), 32'h10};
        vecs[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0};
        vecs[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0, 32'h0};
        vecs[8] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, mem_word(32'h100), 32'h104};

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;
        next_cycle();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_req",   {31'b0, imem_req},    32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr", instr,                32'h0);
        check("rst_pc4",   pc_plus_4,            32'h0);
        check("rst_addr",  imem_addr,            32'h0);
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            instr_ready    = vecs[i].rdy;
            @(negedge clk);
            $display("[TB] vec %0d: req=%0b addr=%h valid=%0b instr=%h pc4=%h",
                     i, imem_req, imem_addr, instr_valid, instr, pc_plus_4);
            check("vec_req",   {31'b0, imem_req},    {31'b0, vecs[i].e_req});
            check("vec_addr",  imem_addr,            vecs[i].e_addr);
            check("vec_valid", {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
            check("vec_instr", instr,                vecs[i].e_instr);
            check("vec_pc4",   pc_plus_4,            vecs[i].e_pc4);
            next_cycle();
        end
        redirect_valid = 1'b0;

        // Stall decode until the queue fills, then drain in order.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        next_cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) next_cycle();
        @(negedge clk);
        $display("[TB] stall: req=%0b valid=%0b instr=%h", imem_req, instr_valid, instr);
        check("stall_req",   {31'b0, imem_req},    32'h0);
        check("stall_valid", {31'b0, instr_valid}, 32'h1);
        check("stall_instr", instr,                mem_word(32'h0));
`ifdef FETCH_PERF_EN
        check("perf_stall_nonzero", {31'b0, perf_stall != 32'h0}, 32'h1);
`endif
        next_cycle();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_pc4", pc_plus_4, 32'(4 * (i + 1)));
            next_cycle();
        end

        // Redirect collides with a pop while full.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        instr_ready    = 1'b0;
        next_cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 7; i++) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        instr_ready    = 1'b1;
        @(negedge clk);
        check("full_before_flush", {31'b0, instr_valid}, 32'h1);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        $display("[TB] flush: valid=%0b addr=%h req=%0b", instr_valid, imem_addr, imem_req);
        check("flush_valid", {31'b0, instr_valid}, 32'h0);
        check("flush_addr",  imem_addr,            32'h200);
        check("flush_req",   {31'b0, imem_req},    32'h1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("flush_head", instr,     mem_word(32'h200));
        check("flush_pc4",  pc_plus_4, 32'h204);
        next_cycle();

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        next_cycle();
        redirect_valid = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("wrap_addr", imem_addr, 32'h0);
        next_cycle();
        @(negedge clk);
        $display("[TB] wrap: instr=%h pc4=%h", instr, pc_plus_4);
        check("wrap_instr", instr,     mem_word(32'hFFFF_FFFC));
        check("wrap_pc4",   pc_plus_4, 32'h0);
        next_cycle();

        // Reset with three entries queued and one read in flight.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        instr_ready    = 1'b0;
        next_cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_req", {31'b0, imem_req}, 32'h0);
        next_cycle();
        reset       = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        $display("[TB] midrst: valid=%0b instr=%h addr=%h", instr_valid, instr, imem_addr);
        check("midrst_valid", {31'b0, instr_valid}, 32'h0);
        check("midrst_instr", instr,                32'h0);
        check("midrst_addr",  imem_addr,            32'h0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("midrst_head", instr, mem_word(32'h0));
        next_cycle();

        // Randomized traffic; the model does all the checking here.
        for (int i = 0; i < 3000; i++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom();
            reset          = ($urandom_range(0, 199) == 0);
            next_cycle();
        end
        reset          = 1'b0;
        redirect_valid = 1'b0;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
